// File: rtl/scoreboard_issue.sv
// Issue-stage register scoreboard: per-GPR in-flight write counters gate operand reads.
// Define SCOREBOARD_HILO_EN to also track the HI/LO pair with its own counter.
module scoreboard_issue #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic                     issue_we,
  input  logic [$clog2(NREG)-1:0]  issue_dest,
  input  logic                     issue_src1_en,
  input  logic                     issue_src2_en,
  input  logic [$clog2(NREG)-1:0]  issue_src1,
  input  logic [$clog2(NREG)-1:0]  issue_src2,
  input  logic                     issue_hilo_we,
  input  logic                     issue_hilo_rd,
  input  logic                     ret_we,
  input  logic [$clog2(NREG)-1:0]  ret_dest,
  input  logic                     ret_hilo_we,
  input  logic                     flush,
  output logic                     stall,
  output logic [NREG-1:0]          pending_vec,
  output logic                     hilo_pending,
  output logic                     sb_err
);

  localparam int unsigned AW = $clog2(NREG);
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Counter update shared by GPRs and HI/LO; simultaneous inc and dec cancel out.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic dec);
    if (inc && !dec) begin
      cnt_step = (cur == CntMax) ? cur : cur + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt_step = (cur == '0) ? cur : cur - CNT_W'(1);
    end else begin
      cnt_step = cur;
    end
  endfunction

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_q, err_d;
  logic [1:0]       guard_q, guard_d;

  logic [CNT_W-1:0] src1_cnt, src2_cnt, dest_cnt, ret_cnt;
  logic             hilo_busy, hilo_full, hilo_under, hilo_over;
  logic             dest_full, fire, inc_en, dec_en;
  logic             gpr_under, gpr_over;

  always_comb begin
    src1_cnt = (int'(issue_src1) < NREG) ? cnt_q[issue_src1] : '0;
    src2_cnt = (int'(issue_src2) < NREG) ? cnt_q[issue_src2] : '0;
    dest_cnt = (int'(issue_dest) < NREG) ? cnt_q[issue_dest] : '0;
    ret_cnt  = (int'(ret_dest) < NREG)   ? cnt_q[ret_dest]   : '0;
  end

`ifdef SCOREBOARD_HILO_EN
  logic [CNT_W-1:0] hilo_cnt_q, hilo_cnt_d;

  assign hilo_busy  = (hilo_cnt_q != '0);
  assign hilo_full  = issue_hilo_we && (hilo_cnt_q == CntMax);
  assign hilo_under = ret_hilo_we && (hilo_cnt_q == '0);
  assign hilo_over  = fire && issue_hilo_we && !ret_hilo_we && (hilo_cnt_q == CntMax);

  always_comb begin
    hilo_cnt_d = cnt_step(hilo_cnt_q, fire && issue_hilo_we, ret_hilo_we);
    if (flush) begin
      hilo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hilo_cnt_q <= '0;
    end else begin
      hilo_cnt_q <= hilo_cnt_d;
    end
  end
`else
  // HI/LO ports stay on the boundary so both builds share one pinout.
  logic unused_hilo;
  assign unused_hilo = issue_hilo_we ^ issue_hilo_rd ^ ret_hilo_we;
  assign hilo_busy   = 1'b0;
  assign hilo_full   = 1'b0;
  assign hilo_under  = 1'b0;
  assign hilo_over   = 1'b0;
`endif

  // Stall reads registered counters only: a retire frees its consumer on the next cycle.
  assign stall = (issue_src1_en && (src1_cnt != '0)) ||
                 (issue_src2_en && (src2_cnt != '0)) ||
                 (issue_hilo_rd && hilo_busy);

  assign dest_full   = (issue_we && (dest_cnt == CntMax)) || hilo_full;
  assign issue_ready = !stall && !dest_full && !flush;
  assign fire        = issue_valid && issue_ready;
  assign inc_en      = fire && issue_we && (issue_dest != '0);
  assign dec_en      = ret_we && (ret_dest != '0);

  assign gpr_under = dec_en && (ret_cnt == '0);
  // Only reachable if the ready handshake is bypassed.
  assign gpr_over  = inc_en && (dest_cnt == CntMax) && !(dec_en && (ret_dest == issue_dest));

  always_comb begin
    cnt_d[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      cnt_d[i] = cnt_step(cnt_q[i], inc_en && (issue_dest == AW'(i)),
                          dec_en && (ret_dest == AW'(i)));
      if (flush) begin
        cnt_d[i] = '0;
      end
    end
  end

  // After a flush, late retires of squashed writes land on zero counters and are expected.
  always_comb begin
    guard_d = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
    err_d   = err_q;
    if (flush) begin
      guard_d = 2'd3;
    end else begin
      if ((gpr_under || hilo_under) && (guard_q == 2'd0)) begin
        err_d = 1'b1;
      end
      if (gpr_over || hilo_over) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      err_q   <= 1'b0;
      guard_q <= 2'd0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q   <= err_d;
      guard_q <= guard_d;
    end
  end

  always_comb begin
    pending_vec[0] = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      pending_vec[i] = (cnt_q[i] != '0);
    end
  end

  assign hilo_pending = hilo_busy;
  assign sb_err       = err_q;

endmodule

// File: tb/tb_scoreboard_issue.sv
// Directed bench for scoreboard_issue; expectations are queued with the stimulus and
// drained against the DUT on the falling edge of each cycle.
module tb_scoreboard_issue;

  localparam int unsigned NREG  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned AW    = 5;
`ifdef SCOREBOARD_HILO_EN
  localparam logic HiloEn = 1'b1;
`else
  localparam logic HiloEn = 1'b0;
`endif

  localparam int SelStall = 0;
  localparam int SelReady = 1;
  localparam int SelPend  = 2;
  localparam int SelHilo  = 3;
  localparam int SelErr   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid, issue_ready, issue_we;
  logic [AW-1:0] issue_dest, issue_src1, issue_src2;
  logic          issue_src1_en, issue_src2_en, issue_hilo_we, issue_hilo_rd;
  logic          ret_we, ret_hilo_we, flush;
  logic [AW-1:0] ret_dest;
  logic          stall, hilo_pending, sb_err;
  logic [NREG-1:0] pending_vec;

  int n_checks = 0;
  int n_errors = 0;

  string       tag_q[$];
  int          sel_q[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  scoreboard_issue #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_we     (issue_we),
    .issue_dest   (issue_dest),
    .issue_src1_en(issue_src1_en),
    .issue_src2_en(issue_src2_en),
    .issue_src1   (issue_src1),
    .issue_src2   (issue_src2),
    .issue_hilo_we(issue_hilo_we),
    .issue_hilo_rd(issue_hilo_rd),
    .ret_we       (ret_we),
    .ret_dest     (ret_dest),
    .ret_hilo_we  (ret_hilo_we),
    .flush        (flush),
    .stall        (stall),
    .pending_vec  (pending_vec),
    .hilo_pending (hilo_pending),
    .sb_err       (sb_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input string tag, input int sel, input logic [63:0] v);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endfunction

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SelStall: observe = 64'(stall);
      SelReady: observe = 64'(issue_ready);
      SelPend:  observe = 64'(pending_vec);
      SelHilo:  observe = 64'(hilo_pending);
      SelErr:   observe = 64'(sb_err);
      default:  observe = 64'hdead;
    endcase
  endfunction

  // Compare queued expectations mid-cycle, then advance past the next rising edge.
  task automatic step();
    @(negedge clk);
    while (sel_q.size() > 0) begin
      check_eq(tag_q.pop_front(), observe(sel_q.pop_front()), exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid   = 1'b0;
    issue_we      = 1'b0;
    issue_dest    = '0;
    issue_src1_en = 1'b0;
    issue_src2_en = 1'b0;
    issue_src1    = '0;
    issue_src2    = '0;
    issue_hilo_we = 1'b0;
    issue_hilo_rd = 1'b0;
    ret_we        = 1'b0;
    ret_dest      = '0;
    ret_hilo_we   = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic issue_wr(input logic [AW-1:0] d);
    idle();
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    issue_dest  = d;
  endtask

  task automatic retire(input logic [AW-1:0] d);
    idle();
    ret_we   = 1'b1;
    ret_dest = d;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    push_exp("rst_stall", SelStall, 64'd0);
    push_exp("rst_pend", SelPend, 64'd0);
    push_exp("rst_hilo", SelHilo, 64'd0);
    push_exp("rst_err", SelErr, 64'd0);
    push_exp("rst_ready", SelReady, 64'd1);
    step();
    flush = 1'b1;
    push_exp("rst_ready_flush", SelReady, 64'd0);
    step();
    reset = 1'b0;
    idle();
    step();

    // Basic RAW hazard on r5
    issue_wr(5'd5);
    push_exp("raw_issue_ready", SelReady, 64'd1);
    step();
    idle();
    issue_src1_en = 1'b1;
    issue_src1    = 5'd5;
    issue_valid   = 1'b1;
    push_exp("raw_stall", SelStall, 64'd1);
    push_exp("raw_pend", SelPend, 64'd1 << 5);
    push_exp("raw_ready", SelReady, 64'd0);
    step();
    ret_we   = 1'b1;
    ret_dest = 5'd5;
    push_exp("raw_no_bypass", SelStall, 64'd1);
    step();
    ret_we = 1'b0;
    push_exp("raw_unstall", SelStall, 64'd0);
    push_exp("raw_pend_clr", SelPend, 64'd0);
    step();

    // Saturate r7 at three in-flight writes
    for (int k = 0; k < 3; k++) begin
      issue_wr(5'd7);
      push_exp("sat_ready", SelReady, 64'd1);
      step();
    end
    issue_wr(5'd7);
    push_exp("sat_full_ready", SelReady, 64'd0);
    push_exp("sat_pend", SelPend, 64'd1 << 7);
    step();
    retire(5'd7);
    step();
    retire(5'd7);
    step();
    retire(5'd7);
    push_exp("sat_last_pend", SelPend, 64'd1 << 7);
    step();
    idle();
    push_exp("sat_drained", SelPend, 64'd0);
    push_exp("sat_err", SelErr, 64'd0);
    step();

    // Same-cycle issue and retire on r9
    issue_wr(5'd9);
    step();
    issue_wr(5'd9);
    ret_we   = 1'b1;
    ret_dest = 5'd9;
    push_exp("same_ready", SelReady, 64'd1);
    step();
    idle();
    push_exp("same_pend", SelPend, 64'd1 << 9);
    step();
    retire(5'd9);
    step();
    idle();
    push_exp("same_pend_clr", SelPend, 64'd0);
    push_exp("same_err", SelErr, 64'd0);
    step();

    // r0 is never tracked
    issue_wr(5'd0);
    issue_src1_en = 1'b1;
    issue_src1    = 5'd0;
    push_exp("r0_stall", SelStall, 64'd0);
    push_exp("r0_ready", SelReady, 64'd1);
    step();
    retire(5'd0);
    issue_src1_en = 1'b1;
    push_exp("r0_stall2", SelStall, 64'd0);
    push_exp("r0_pend", SelPend, 64'd0);
    step();
    idle();
    push_exp("r0_ret_err", SelErr, 64'd0);
    step();

    // src2 path
    issue_wr(5'd10);
    step();
    idle();
    issue_src2_en = 1'b1;
    issue_src2    = 5'd10;
    issue_src1    = 5'd10;
    push_exp("src2_stall", SelStall, 64'd1);
    step();
    issue_src2_en = 1'b0;
    push_exp("src2_dis", SelStall, 64'd0);
    step();
    retire(5'd10);
    step();

    // Flush with r3 at two, then late retire is dropped silently
    issue_wr(5'd3);
    step();
    issue_wr(5'd3);
    step();
    issue_wr(5'd3);
    flush    = 1'b1;
    ret_we   = 1'b1;
    ret_dest = 5'd3;
    push_exp("flush_ready", SelReady, 64'd0);
    push_exp("flush_pend_before", SelPend, 64'd1 << 3);
    step();
    retire(5'd3);
    push_exp("flush_pend", SelPend, 64'd0);
    step();
    idle();
    push_exp("flush_pend2", SelPend, 64'd0);
    push_exp("flush_err", SelErr, 64'd0);
    step();
    step();
    step();
    step();
    retire(5'd4);
    push_exp("pre_under_err", SelErr, 64'd0);
    step();
    idle();
    push_exp("under_err", SelErr, 64'd1);
    step();
    step();
    push_exp("err_sticky", SelErr, 64'd1);
    step();

    // Reset overrides concurrent issue/retire/flush
    issue_wr(5'd6);
    ret_we   = 1'b1;
    ret_dest = 5'd8;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    idle();
    push_exp("midrst_err", SelErr, 64'd0);
    push_exp("midrst_pend", SelPend, 64'd0);
    step();

    // HI/LO tracking
    idle();
    issue_valid   = 1'b1;
    issue_hilo_we = 1'b1;
    step();
    idle();
    issue_hilo_rd = 1'b1;
    push_exp("hilo_stall", SelStall, 64'(HiloEn));
    push_exp("hilo_pend", SelHilo, 64'(HiloEn));
    step();
    ret_hilo_we = 1'b1;
    push_exp("hilo_no_bypass", SelStall, 64'(HiloEn));
    step();
    ret_hilo_we = 1'b0;
    push_exp("hilo_unstall", SelStall, 64'd0);
    push_exp("hilo_pend_clr", SelHilo, 64'd0);
    push_exp("hilo_err", SelErr, 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
